// File: rtl/core_seq_pkg.sv
// rtl/core_seq_pkg.sv - state encoding, opcode constants and legality check for the sequencer
package core_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_FAULT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic op_is_legal(input logic [6:0] opc);
        case (opc)
            OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
            OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: op_is_legal = 1'b1;
            default:                                        op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - memory-wait watchdog; flags the last permitted waiting cycle
module seq_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;

    // Holds at LAST; the sequencer leaves the waiting state on that cycle anyway.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wait_cnt <= '0;
        end else if (count_en && (wait_cnt != LAST)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign expired = count_en && (wait_cnt == LAST);

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle RV32I stage sequencer with watchdog, sticky fault and retire counter
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic        dec_reg_write,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_en,
    output logic        mdr_en,
    output logic        pc_en,
    output logic        rf_we,
    output logic        fault,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    state_t      state_q;
    state_t      state_next;
    logic [31:0] instret_q;
    logic        expired;
    logic        is_load;
    logic        is_store;
    logic        mem_req_c;
    logic        mem_we_c;
    logic        addr_sel_c;
    logic        ir_en_c;
    logic        mdr_en_c;
    logic        pc_en_c;
    logic        rf_we_c;
    logic        fault_c;

    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);

    seq_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_next != state_q),
        .count_en (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_next;
            instret_q <= instret_q + 32'(pc_en_c);
        end
    end

    always_comb begin
        state_next = state_q;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        addr_sel_c = 1'b0;
        ir_en_c    = 1'b0;
        mdr_en_c   = 1'b0;
        pc_en_c    = 1'b0;
        rf_we_c    = 1'b0;
        fault_c    = 1'b0;
        case (state_q)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_en_c    = 1'b1;
                    state_next = S_DECODE;
                end else if (expired) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: state_next = op_is_legal(op) ? S_EXECUTE : S_FAULT;
            S_EXECUTE: begin
                if (is_load || is_store) begin
                    state_next = S_MEM;
                end else if (dec_reg_write) begin
                    state_next = S_WB;
                end else begin
                    pc_en_c    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req_c  = 1'b1;
                addr_sel_c = 1'b1;
                mem_we_c   = is_store;
                if (mem_ready) begin
                    if (is_load) begin
                        mdr_en_c   = 1'b1;
                        state_next = S_WB;
                    end else begin
                        pc_en_c    = 1'b1;
                        state_next = S_FETCH;
                    end
                end else if (expired) begin
                    state_next = S_FAULT;
                end
            end
            S_WB: begin
                rf_we_c    = 1'b1;
                pc_en_c    = 1'b1;
                state_next = S_FETCH;
            end
            S_FAULT: fault_c = 1'b1;
            default: state_next = S_FAULT;
        endcase
    end

    // Reset masks every output so no enable can fire in the reset cycle itself.
    assign mem_req  = mem_req_c  & ~rst;
    assign mem_we   = mem_we_c   & ~rst;
    assign addr_sel = addr_sel_c & ~rst;
    assign ir_en    = ir_en_c    & ~rst;
    assign mdr_en   = mdr_en_c   & ~rst;
    assign pc_en    = pc_en_c    & ~rst;
    assign rf_we    = rf_we_c    & ~rst;
    assign fault    = fault_c    & ~rst;
    assign state    = rst ? 3'd0 : state_q;
    assign instret  = rst ? 32'd0 : instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized self-checking bench for core_sequencer
module tb_core_sequencer;

    localparam int TMO = 4;
    localparam logic [2:0] ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
    localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_FAULT = 3'd7;
    localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ADD = 7'b0110011, OPC_BEQ = 7'b1100011;

    logic [6:0] legal_ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                   7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                   7'b0010111, 7'b0001111, 7'b1110011};

    // flags: req, we, asel, ir, mdr, pc, rf, flt
    typedef struct packed {
        logic [2:0] st;
        logic [7:0] f;
    } obs_t;
    typedef struct packed {
        obs_t o;
        logic rdy;
    } step_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  op = 7'd0;
    logic        dec_reg_write = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_en, mdr_en, pc_en, rf_we, fault;
    logic [2:0]  state;
    logic [31:0] instret;
    obs_t        obs;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] instret_model = 32'd0;
    step_t       trace[$];
    bit          trace_retires;
    bit          trace_faults;

    core_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .op(op), .dec_reg_write(dec_reg_write), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_en(ir_en),
        .mdr_en(mdr_en), .pc_en(pc_en), .rf_we(rf_we), .fault(fault),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    assign obs = {state, mem_req, mem_we, addr_sel, ir_en, mdr_en, pc_en, rf_we, fault};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    function automatic bit is_legal(input logic [6:0] opc);
        foreach (legal_ops[i]) if (legal_ops[i] == opc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void add(input logic [2:0] st, input logic [7:0] f, input logic rdy);
        step_t s;
        s.o   = {st, f};
        s.rdy = rdy;
        trace.push_back(s);
    endfunction

    // Expected per-cycle outputs for one instruction, from its class and memory wait counts.
    function automatic void build(input logic [6:0] opc, input logic drw, input int fw, input int mw);
        logic ld = (opc == OPC_LOAD);
        logic sd = (opc == OPC_STORE);
        trace.delete();
        trace_retires = 1'b0;
        trace_faults  = 1'b0;
        for (int i = 0; i < fw && i < TMO; i++) add(ST_FETCH, 8'b1000_0000, 1'b0);
        if (fw >= TMO) begin
            add(ST_FAULT, 8'b0000_0001, 1'($urandom));
            trace_faults = 1'b1;
            return;
        end
        add(ST_FETCH, 8'b1001_0000, 1'b1);
        add(ST_DECODE, 8'b0, 1'($urandom));
        if (!is_legal(opc)) begin
            add(ST_FAULT, 8'b0000_0001, 1'($urandom));
            trace_faults = 1'b1;
            return;
        end
        if (ld || sd) begin
            add(ST_EXEC, 8'b0, 1'($urandom));
            for (int i = 0; i < mw && i < TMO; i++)
                add(ST_MEM, {1'b1, sd, 1'b1, 5'b0}, 1'b0);
            if (mw >= TMO) begin
                add(ST_FAULT, 8'b0000_0001, 1'($urandom));
                trace_faults = 1'b1;
                return;
            end
            add(ST_MEM, {1'b1, sd, 1'b1, 1'b0, ld, sd, 2'b0}, 1'b1);
            if (ld) add(ST_WB, 8'b0000_0110, 1'($urandom));
        end else if (drw) begin
            add(ST_EXEC, 8'b0, 1'($urandom));
            add(ST_WB, 8'b0000_0110, 1'($urandom));
        end else begin
            add(ST_EXEC, 8'b0000_0100, 1'($urandom));
        end
        trace_retires = 1'b1;
    endfunction

    task automatic run_instr(input string name, input logic [6:0] opc, input logic drw,
                             input int fw, input int mw, input int limit);
        int n;
        build(opc, drw, fw, mw);
        n = (limit < 0) ? trace.size() : limit;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            op = opc;
            dec_reg_write = drw;
            mem_ready = trace[i].rdy;
            #1;
            checks++;
            if (obs !== trace[i].o) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs %b, expected %b", name, i, obs, trace[i].o);
            end
            if (i == 0) begin
                checks++;
                if (instret !== instret_model) begin
                    errors++;
                    $display("FAIL %s instret: got %h, expected %h", name, instret, instret_model);
                end
            end
        end
        if (limit < 0 && trace_retires) instret_model = instret_model + 32'd1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1;
            mem_ready = 1'($urandom);
            op = OPC_LOAD;
            #1;
            checks++;
            if (obs !== 11'b0 || instret !== 32'd0) begin
                errors++;
                $display("FAIL reset_active: outputs %b instret %h, expected all zero", obs, instret);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 11'b0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL reset_release: outputs %b instret %h, expected all zero", obs, instret);
        end
        instret_model = 32'd0;
    endtask

    task automatic test_fault_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            op = 7'($urandom);
            #1;
            checks++;
            if (obs !== {ST_FAULT, 8'b0000_0001} || instret !== instret_model) begin
                errors++;
                $display("FAIL fault_hold: outputs %b instret %h, expected %b instret %h",
                         obs, instret, {ST_FAULT, 8'b0000_0001}, instret_model);
            end
        end
    endtask

    task automatic test_basic();
        run_instr("add", OPC_ADD, 1'b1, 0, 0, -1);
        run_instr("lw_wait3", OPC_LOAD, 1'b1, 0, 3, -1);
        run_instr("sw", OPC_STORE, 1'b0, 0, 0, -1);
        run_instr("beq", OPC_BEQ, 1'b0, 0, 0, -1);
        run_instr("illegal", 7'b0000000, 1'b0, 0, 0, -1);
        test_fault_hold(6);
        test_reset();
    endtask

    task automatic test_timeout();
        run_instr("fetch_timeout", OPC_ADD, 1'b1, TMO, 0, -1);
        test_fault_hold(2);
        test_reset();
        run_instr("fetch_ready_last", OPC_ADD, 1'b1, TMO - 1, 0, -1);
        run_instr("mem_ready_last", OPC_STORE, 1'b0, 0, TMO - 1, -1);
        run_instr("mem_timeout", OPC_LOAD, 1'b1, 0, TMO, -1);
        test_fault_hold(2);
        test_reset();
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [6:0] opc;
            logic       drw;
            int         fw;
            int         mw;
            if ($urandom_range(0, 9) == 0) begin
                do opc = 7'($urandom); while (is_legal(opc));
            end else begin
                opc = legal_ops[$urandom_range(0, 10)];
            end
            drw = 1'($urandom);
            fw = ($urandom_range(0, 19) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
            mw = ($urandom_range(0, 19) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
            run_instr("random", opc, drw, fw, mw, -1);
            if (trace_faults) begin
                test_fault_hold(1);
                test_reset();
            end
        end
    endtask

    task automatic test_wrap();
        test_reset();
        force dut.instret_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.instret_q;
        instret_model = 32'hFFFF_FFFF;
        run_instr("wrap_beq", OPC_BEQ, 1'b0, 0, 0, -1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (instret !== 32'd0) begin
            errors++;
            $display("FAIL instret_wrap: got %h, expected 00000000", instret);
        end
    endtask

    task automatic test_rst_mid();
        test_reset();
        run_instr("pre_add", OPC_ADD, 1'b1, 0, 0, -1);
        run_instr("rst_mid_lw", OPC_LOAD, 1'b1, 0, 2, 4);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== 11'b0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL rst_in_mem: outputs %b instret %h, expected all zero", obs, instret);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 11'b0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL after_rst_in_mem: outputs %b instret %h, expected all zero", obs, instret);
        end
        instret_model = 32'd0;
        run_instr("post_rst_add", OPC_ADD, 1'b1, 0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_random();
        test_wrap();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
